// File: rtl/aes_mc_serial_forward.sv
// aes_mc_serial_forward
// Forward AES MixColumns over a 128-bit state. The block processes COLS_PER_CYCLE
// columns per busy cycle through combinational single-column multipliers.
// It uses valid/ready handshakes on both the input and output sides.
// Column c = data[32*c +: 32]; row r of a column = bits [8*r +: 8].
// Optional macro AES_MC_INV_EN adds an 'inv' input.
// 'inv' is latched per block and selects the inverse MixColumns coefficients.
module aes_mc_serial_forward #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef AES_MC_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int         NB       = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(NB - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("aes_mc_serial_forward: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e        st_q, st_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [127:0]  data_q, data_d;
  logic          ready_raw;
  logic          load;

  // GF(2^8) multiply by 02 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One forward MixColumns column: rows use 02/03/01/01 rotated by row index.
  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, d0, d1, d2, d3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    return {(d0 ^ a0) ^ a1 ^ a2 ^ d3,
            a0 ^ a1 ^ d2 ^ (d3 ^ a3),
            a0 ^ d1 ^ (d2 ^ a2) ^ a3,
            d0 ^ (d1 ^ a1) ^ a2 ^ a3};
  endfunction

`ifdef AES_MC_INV_EN
  logic mode_q, mode_d;

  // One inverse MixColumns column: rows use 0E/0B/0D/09 rotated by row index.
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[8*k +: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  // Column transform selected by the per-block mode flag.
  function automatic logic [31:0] lane_mix(input logic [31:0] c, input logic inv_sel);
    return inv_sel ? inv_mix(c) : fwd_mix(c);
  endfunction
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    st_d      = st_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ready_raw = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
`ifdef AES_MC_INV_EN
    mode_d    = mode_q;
`endif
    unique case (st_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          st_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Replace this cycle's group of columns in place; earlier groups are left untouched.
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          int col;
          col = int'(cnt_q) * COLS_PER_CYCLE + g;
`ifdef AES_MC_INV_EN
          data_d[32*col +: 32] = lane_mix(data_q[32*col +: 32], mode_q);
`else
          data_d[32*col +: 32] = fwd_mix(data_q[32*col +: 32]);
`endif
        end
        if (cnt_q == LAST_GRP) begin
          cnt_d = 2'd0;
          st_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        ready_raw = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load = 1'b1;
            st_d = ST_BUSY;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (load) begin
      data_d = in_data;
      cnt_d  = 2'd0;
`ifdef AES_MC_INV_EN
      mode_d = inv;
`endif
    end
  end

  // Keep in_ready low while reset is held; it rises as soon as reset is released in IDLE.
  assign in_ready = ready_raw & rst_n;
  assign out_data = data_q;

  // FSM, group counter and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= 2'd0;
      // NOTE: the state register is reset too, so out_data reads zero during reset and a partial block is discarded.
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

`ifdef AES_MC_INV_EN
  // Per-block transform direction, captured at the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
`endif

endmodule

// File: doc/aes_mc_serial_forward.md
Name: aes_mc_serial_forward

Overview:
- Forward AES MixColumns over a full 128-bit state.
- Columns are processed sequentially through COLS_PER_CYCLE combinational single-column multipliers (GF(2^8) xtime-based, coefficients 02/03/01/01), with valid/ready handshakes on both sides.
- Sits in the encryption datapath; it is the encrypt-side counterpart of the single-column inverse MixColumns used for decryption.
- Trades area for latency.

Parameters:
- COLS_PER_CYCLE, default 1, number of columns transformed per busy cycle; legal values 1, 2, 4. Busy cycles per block: NB = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state valid
- in_ready  output  1  block can accept a state this cycle
- in_data  input  128  state; column c = in_data[32*c +: 32], row r of that column = bits [8*r +: 8]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  128  MixColumns result, same byte layout as in_data

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, column counter=0, state register=0.
  - Output values during reset: out_valid=0, in_ready=0, out_data=0.
  - in_ready rises only in the first cycle after rst_n deasserts.
- Per-column function, bytes a0..a3 (row 0..3):
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
  - 2x = xtime: (x<<1) ^ (x[7] ? 0x1B : 0x00), 8-bit result.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. in_valid=1 loads in_data into the state register, counter=0, next state BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle, columns [counter*COLS_PER_CYCLE, +COLS_PER_CYCLE) are replaced in place by their transform; counter increments.
    - After the last group, next state DONE and counter wraps to 0.
  - DONE: out_valid=1, out_data=state register, held stable until out_ready=1.
    - in_ready=out_ready. Both handshakes in the same cycle: result retired and new state loaded, next state BUSY (back-to-back).
    - out_ready=1 with in_valid=0: next state IDLE.
- Latency: out_valid high NB+1 cycles after the in_valid&in_ready cycle. With COLS_PER_CYCLE=1 that is 5 cycles; sustained throughput is one block per 5 cycles.
- in_data is ignored outside the handshake cycle. out_data is not guaranteed outside DONE. Already-processed columns are never re-processed.
- in_valid may drop without completing a handshake; it has no effect.
- Reset asserted mid-BUSY or in DONE aborts the block immediately and discards the partial result.
- Illegal COLS_PER_CYCLE: elaboration error.

Optional Feature:
- AES_MC_INV_EN defined:
  - Adds input port inv (1 bit), sampled at the input handshake and held in a mode flag for the rest of the block.
  - inv=1 selects inverse MixColumns coefficients (0E/0B/0D/09, same row rotation).
  - The mode flag resets to 0.
- AES_MC_INV_EN undefined: no inv port; forward transform only; no inverse logic synthesized.

Test Plan:
- Single column (COLS_PER_CYCLE=1):
  - in_data[31:0]=0x455313DB, other columns 0 -> out_data[31:0]=0xBCA14D8E, other columns 0.
  - out_valid asserted exactly 5 cycles after the handshake.
- FIPS-197 columns: in_data={0xD5D4D4D4,0x01010101,0xC6C6C6C6,0x5C220AF2} (col3..col0) -> {0xD6D7D5D5,0x01010101,0xC6C6C6C6,0x9D58DC9F}. Repeat for COLS_PER_CYCLE=2 and 4; latency must be 3 and 2 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 -> both handshakes in one cycle, next result 5 cycles later.
- Reset: assert rst_n=0 two cycles into BUSY -> out_valid=0 immediately, FSM IDLE. A new block after release produces the correct result.
- AES_MC_INV_EN: inv=1, in_data[31:0]=0xBCA14D8E -> 0x455313DB. A forward block submitted right after is unaffected, i.e. the mode is latched per block.
- Random: 10k random states, alternating random in_valid/out_ready -> matches the software MixColumns model; no result dropped or duplicated.
